// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TL-UL channel types for the host arbiter
package tlul_pkg;
  parameter int TL_AW = 32;
  parameter int TL_DW = 32;
  parameter int TL_AIW = 8;
  parameter int TL_DIW = 1;
  parameter int TL_SZW = 2;
  parameter int TL_DBW = TL_DW / 8;
  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/student_tlul_host_arb.sv
// student_tlul_host_arb: round-robin TL-UL host arbiter with source tagging and per-host outstanding limits
module student_tlul_host_arb #(
  parameter int NumHosts = 4,
  parameter int IdxW = $clog2(NumHosts),
  parameter int MaxOutstanding = 4,
  parameter int SrcW = tlul_pkg::TL_AIW
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  tlul_pkg::tl_h2d_t [NumHosts-1:0]    tl_h_i,
  output tlul_pkg::tl_d2h_t [NumHosts-1:0]    tl_h_o,
  output tlul_pkg::tl_h2d_t                   tl_host_o,
  input  tlul_pkg::tl_d2h_t                   tl_host_i,
  output logic                                busy_o,
  output logic [NumHosts-1:0]                 err_src_o
);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, sel, d_idx;
  logic [NumHosts-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NumHosts-1:0] err_q, err_d, elig, a_hs, d_hs;
  logic any_elig;
  tlul_pkg::tl_h2d_t req;
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return IdxW'(s >= NumHosts ? s - NumHosts : s);
  endfunction
  assign req = tl_h_i[gnt_q];
  assign d_idx = tl_host_i.d_source[SrcW-1 -: IdxW];
  assign busy_o = |cnt_q;
  assign err_src_o = err_q;
  always_comb begin
    elig = '0;
    sel = ptr_q;
    any_elig = 1'b0;
    for (int i = 0; i < NumHosts; i++) elig[i] = tl_h_i[i].a_valid && cnt_q[i] < CntW'(MaxOutstanding);
    for (int k = NumHosts - 1; k >= 0; k--) begin
      if (elig[wrap_inc(ptr_q, k)]) begin
        sel = wrap_inc(ptr_q, k);
        any_elig = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    a_hs = '0;
    d_hs = '0;
    cnt_d = cnt_q;
    err_d = err_q;
    tl_host_o = '0;
    tl_h_o = '0;
    if (state_q == GRANT) begin
      tl_host_o = req;
      tl_host_o.d_ready = 1'b0;
      tl_host_o.a_source = {gnt_q, req.a_source[SrcW-IdxW-1:0]};
      a_hs[gnt_q] = req.a_valid && tl_host_i.a_ready;
      state_d = (req.a_valid && !tl_host_i.a_ready) ? GRANT : IDLE;
      ptr_d = a_hs[gnt_q] ? wrap_inc(gnt_q, 1) : ptr_q;
    end else if (any_elig) begin
      state_d = GRANT;
      gnt_d = sel;
    end
    for (int i = 0; i < NumHosts; i++) begin
      if (tl_host_i.d_valid && d_idx == IdxW'(i)) begin
        tl_h_o[i] = tl_host_i;
        tl_h_o[i].d_source = {{IdxW{1'b0}}, tl_host_i.d_source[SrcW-IdxW-1:0]};
        tl_host_o.d_ready = tl_h_i[i].d_ready;
        d_hs[i] = tl_h_i[i].d_ready;
      end
      tl_h_o[i].a_ready = state_q == GRANT && gnt_q == IdxW'(i) && tl_host_i.a_ready;
      err_d[i] = err_q[i] | (a_hs[i] & |tl_h_i[i].a_source[SrcW-1 -: IdxW]);
      cnt_d[i] = (a_hs[i] && !d_hs[i] && cnt_q[i] != CntW'(MaxOutstanding)) ? cnt_q[i] + 1'b1 :
                 (d_hs[i] && !a_hs[i] && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule
